// File: rtl/gate_sequence_accumulator.sv
// gate_sequence_accumulator: accumulates a 2x2 complex gate-sequence product
// through an external matrix multiplier, reusing a per-index prefix cache.
module gate_sequence_accumulator #(
  parameter int WIDTH       = 19,
  parameter int GATE_BITS   = 5,
  parameter int CACHE_DEPTH = 8,
  parameter int RIGHT_MUL   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [GATE_BITS-1:0]   seq_index,
  input  logic [GATE_BITS-1:0]   seq_gate,
  input  logic                   ready,
  input  logic                   first,
  output logic                   available,
  output logic [8*WIDTH-1:0]     result_mtx,
  output logic                   done,
  output logic                   cache_hit,
  output logic                   seq_error,
  output logic [GATE_BITS-1:0]   gate_addr,
  input  logic [8*WIDTH-1:0]     gate_mtx,
  output logic [8*WIDTH-1:0]     multiplier_a,
  output logic [8*WIDTH-1:0]     multiplier_b,
  input  logic [8*WIDTH-1:0]     multiplier_result,
  output logic                   multiplier_ready,
  input  logic                   multiplier_done
);

  localparam int MW = 8 * WIDTH;
  localparam int CW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = CACHE_DEPTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]             r_state;
  logic [GATE_BITS-1:0]   r_idx;
  logic [GATE_BITS-1:0]   r_gate;
  logic [GATE_BITS-1:0]   r_top;
  logic [GATE_BITS-1:0]   r_addr;
  logic                   r_first;
  logic                   r_match;
  logic                   r_err;
  logic                   r_done;
  logic                   r_hit;
  logic                   r_mready;
  logic [MW-1:0]          r_p;
  logic [MW-1:0]          r_a;
  logic [MW-1:0]          r_b;
  logic [CACHE_DEPTH-1:0] r_valid;
  logic [GATE_BITS-1:0]   r_tag   [CACHE_DEPTH];
  logic [MW-1:0]          r_cache [CACHE_DEPTH];

  logic                   w_in_range;
  logic [CW-1:0]          w_cidx;
  logic                   w_hit;
  logic                   w_mul_st;
  logic                   w_fill;
  logic                   w_idx0;
  logic [MW-1:0]          w_new_p;
  logic [GATE_BITS-1:0]   w_prev_m1;

  assign w_in_range = {{(32-GATE_BITS){1'b0}}, r_idx} < DEPTH_U;
  assign w_cidx     = r_idx[CW-1:0];
  assign w_hit      = r_match && w_in_range && r_valid[w_cidx] &&
                      (r_tag[w_cidx] == r_gate);
  assign w_mul_st   = (r_state == S_MUL) || (r_state == S_WAIT);
  assign w_fill     = ((r_state == S_FETCH) && r_first) ||
                      (w_mul_st && multiplier_done);
  assign w_idx0     = (r_idx == '0);
  assign w_new_p    = (r_state == S_FETCH) ? gate_mtx : multiplier_result;
  assign w_prev_m1  = r_idx - {{(GATE_BITS-1){1'b0}}, 1'b1};

  // Cache payload needs no reset: the valid bits guard every read.
  always_ff @(posedge clk) begin
    if (w_fill && w_in_range) begin
      r_cache[w_cidx] <= w_new_p;
      r_tag[w_cidx]   <= r_gate;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_gate   <= '0;
      r_top    <= '0;
      r_addr   <= '0;
      r_first  <= 1'b0;
      r_match  <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_hit    <= 1'b0;
      r_mready <= 1'b0;
      r_p      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_valid  <= '0;
    end else begin
      r_done   <= 1'b0;
      r_hit    <= 1'b0;
      r_mready <= 1'b0;
      // A freshly computed prefix makes every deeper entry stale.
      if (w_fill && w_in_range) begin
        for (int i = 0; i < CACHE_DEPTH; i++)
          if (i < int'(r_idx)) r_valid[i] <= 1'b0;
        r_valid[w_cidx] <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_idx   <= seq_index;
            r_gate  <= seq_gate;
            r_addr  <= seq_gate;
            r_first <= first;
            r_state <= S_LOOKUP;
            if (first) begin
              r_match <= (seq_index == r_top);
              r_err   <= 1'b0;
              if (seq_index != r_top) begin
                r_valid <= '0;
                r_top   <= seq_index;
              end
            end else if (seq_index != w_prev_m1) begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_p     <= r_cache[w_cidx];
            r_hit   <= 1'b1;
            r_done  <= w_idx0;
            r_state <= S_IDLE;
          end else begin
            r_match <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_first) begin
            r_p     <= gate_mtx;
            r_done  <= w_idx0;
            r_state <= S_IDLE;
          end else begin
            if (RIGHT_MUL != 0) begin
              r_a <= r_p;
              r_b <= gate_mtx;
            end else begin
              r_a <= gate_mtx;
              r_b <= r_p;
            end
            r_mready <= 1'b1;
            r_state  <= S_MUL;
          end
        end
        S_MUL, S_WAIT: begin
          if (multiplier_done) begin
            r_p     <= multiplier_result;
            r_done  <= w_idx0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign available        = (r_state == S_IDLE);
  assign result_mtx       = r_p;
  assign done             = r_done;
  assign cache_hit        = r_hit;
  assign seq_error        = r_err;
  assign gate_addr        = r_addr;
  assign multiplier_a     = r_a;
  assign multiplier_b     = r_b;
  assign multiplier_ready = r_mready;

endmodule

// File: doc/gate_sequence_accumulator.md
# gate_sequence_accumulator

Parametrised successor to the single-sequence gate multiplier. Accepts a gate sequence one element at a time, from the highest index down to index 0. It accumulates the 2x2 complex matrix product through the shared external complex matrix multiplier and presents the final unitary to later compiler stages. A per-index prefix cache skips multiplies when a new sequence shares a leading prefix with the previous one. Parameters control word width, gate-ID width, cache depth and multiplication order.

## Interface
- WIDTH, 19: signed fixed-point width of one real or imaginary component.
- GATE_BITS, 5: width of gate ID and sequence index.
- CACHE_DEPTH, 8: number of cached prefix entries, indices 0..CACHE_DEPTH-1.
- RIGHT_MUL, 1: 1 gives P_new = P_old x G; 0 gives P_new = G x P_old.
- Matrix packing for every 8*WIDTH bus: element (r,c,p) occupies slice [(r*4+c*2+p)*WIDTH +: WIDTH]. p=0 is real, p=1 is imaginary.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- seq_index  in  GATE_BITS  position of the presented element.
- seq_gate  in  GATE_BITS  gate ID of the presented element.
- ready  in  1  element valid; accepted only while available=1.
- first  in  1  element starts a new sequence.
- available  out  1  block idle, can accept an element.
- result_mtx  out  8*WIDTH  accumulated product.
- done  out  1  one-cycle pulse: element at index 0 finished.
- cache_hit  out  1  one-cycle pulse: last element served from cache.
- seq_error  out  1  sticky: index out of order; cleared by the next accepted first.
- gate_addr  out  GATE_BITS  gate ROM address.
- gate_mtx  in  8*WIDTH  gate ROM data, valid 1 cycle after gate_addr.
- multiplier_a, multiplier_b  out  8*WIDTH  multiplier operands.
- multiplier_result  in  8*WIDTH  multiplier product.
- multiplier_ready  out  1  one-cycle start pulse to the multiplier.
- multiplier_done  in  1  multiplier completion pulse.

## Operation
- States: IDLE, LOOKUP, FETCH, MUL, WAIT.
- available = (state==IDLE).
- **IDLE**
  - On ready: register index and gate, drive gate_addr=seq_gate, go to LOOKUP.
  - If first=1: match_chain <= (seq_index==cached_top) and seq_error <= 0. If seq_index != cached_top, invalidate all entries and set cached_top <= seq_index.
  - If first=0 and seq_index != prev_index-1: set seq_error. The element is still processed.
- **LOOKUP**
  - Hit condition: match_chain && idx<CACHE_DEPTH && valid[idx] && tag[idx]==gate.
  - On hit: P <= cache[idx], pulse cache_hit, go to IDLE.
  - Otherwise: match_chain <= 0, go to FETCH.
- **FETCH**
  - If first: P <= gate_mtx, go to IDLE.
  - Otherwise: drive operands per RIGHT_MUL, pulse multiplier_ready, go to MUL.
  - Operands are held stable until multiplier_done.
- **MUL/WAIT**
  - On multiplier_done: P <= multiplier_result, go to IDLE.
- **Cache write** on every miss completion with idx<CACHE_DEPTH:
  - valid[idx] <= 1, tag[idx] <= gate, cache[idx] <= new P.
  - Invalidate all entries with index < idx.
- Indices >= CACHE_DEPTH always miss and are never written.
- result_mtx = P.
- done pulses on the IDLE-return cycle when the completed element had idx==0.
- The block performs no arithmetic of its own. Fixed-point scaling is owned by the multiplier.

## Timing
- Reset values:
  - state IDLE, available=1.
  - done=0, cache_hit=0, seq_error=0, multiplier_ready=0.
  - result_mtx, multiplier_a, multiplier_b, gate_addr = 0.
  - All valid bits 0, cached_top=0, match_chain=0.
- Latency, from the accept edge to the cycle available=1 again:
  - Hit: 2 cycles.
  - First miss: 3 cycles.
  - Multiply miss: 3 cycles + multiplier latency + 1.
- done and cache_hit are asserted in the same cycle that available rises.
- ready while available=0 is ignored. No element is queued.
- ready and first together in IDLE: first handling takes priority. The element is still processed.
- multiplier_done outside MUL/WAIT is ignored.
- Reset mid-operation:
  - Immediately returns to reset values.
  - Cache is fully invalidated.
  - Any in-flight multiplier result is discarded.

## Test plan
- **Reset:** after reset, available=1, done=0, result_mtx=0, no multiplier_ready for 20 cycles.
- **First sequence:** bench ROM G(g)=diag(g+1) real, sequence (idx2,g2),(idx1,g1),(idx0,g0) -> exactly 2 multiplier_ready pulses, done once, result_mtx matches the reference-model product, cache_hit never asserted.
- **Repeat sequence:** same sequence again -> 3 cache_hit pulses, 0 multiplier_ready pulses, each element available again 2 cycles after accept, identical result_mtx.
- **Changed middle gate:** change idx1 to g3 -> hit at idx2, misses at idx1 and idx0, 2 multiplies. Replay the original sequence -> hit at idx2 only.
- **New length:** first at idx3 -> full invalidate, no hits. Then send idx1 after idx3 -> seq_error=1, cleared by the next first.
- **Ignored ready and reset:** ready pulsed during MUL -> ignored. Reset asserted during MUL -> available=1 next cycle, following replay shows no hits.
